// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-addressable word RAM with sized loads and stores, plus
// memory-mapped CYCLE counter, TX byte FIFO and sticky STATUS flags.
module data_mem_responder #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wem,
    input  logic [2:0]  rwmm,
    input  logic [31:0] rwam,
    input  logic [31:0] wdm,
    output logic [31:0] rdm,
    output logic        misalign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data
);

    localparam int AW = $clog2(DEPTH);

    function automatic logic [31:0] f_load(input logic [2:0] mode, input logic [1:0] lane,
                                           input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (mode)
            3'b000:  f_load = {{24{b[7]}}, b};
            3'b001:  f_load = {{16{h[15]}}, h};
            3'b010:  f_load = word;
            3'b100:  f_load = {24'd0, b};
            3'b101:  f_load = {16'd0, h};
            default: f_load = 32'd0;
        endcase
    endfunction

    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_cycle;
    logic [7:0]    r_fifo [4];
    logic [1:0]    r_wr_ptr;
    logic [1:0]    r_rd_ptr;
    logic [2:0]    r_count;
    logic          r_ovf;
    logic          r_misfault;

    logic          w_is_mmio;
    logic [AW-1:0] w_word_idx;
    logic          w_mode_ok;
    logic          w_misalign;
    logic          w_ram_we;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_status;
    logic [31:0]   w_mmio_rdata;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_stat_wr;
    logic [2:0]    w_count_nxt;
    logic          w_unused;

    assign w_unused   = ^rwam[27:AW+2];
    assign w_is_mmio  = (rwam[31:28] == 4'h1);
    assign w_word_idx = rwam[AW+1:2];
    assign w_mode_ok  = (rwmm == 3'b000) || (rwmm == 3'b001) || (rwmm == 3'b010) ||
                        (rwmm == 3'b100) || (rwmm == 3'b101);
    assign w_misalign = !w_is_mmio && w_mode_ok &&
                        ((rwmm[1:0] == 2'b01 && rwam[0]) ||
                         (rwmm[1:0] == 2'b10 && rwam[1:0] != 2'b00));
    assign misalign   = w_misalign;

    // BU/HU store encodings behave like SB/SH: the size is taken from rwmm[1:0]
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = wdm;
        case (rwmm[1:0])
            2'b00: begin
                w_be    = 4'b0001 << rwam[1:0];
                w_wdata = {4{wdm[7:0]}};
            end
            2'b01: begin
                w_be    = rwam[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdm[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_ram_we = reset_n && wem && !w_is_mmio && w_mode_ok && !w_misalign;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_word_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    assign w_full    = (r_count == 3'd4);
    assign w_empty   = (r_count == 3'd0);
    assign out_valid = !w_empty;
    assign out_data  = r_fifo[r_rd_ptr];
    assign w_push    = wem && w_is_mmio && (rwam[3:2] == 2'd1);
    assign w_pop     = out_valid && out_ready;
    // A full FIFO still takes the push when the head leaves on the same edge
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_stat_wr = wem && w_is_mmio && (rwam[3:2] == 2'd2);
    assign w_status  = {22'd0, r_misfault, r_ovf, 3'd0, r_count, w_empty, w_full};

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop)      w_count_nxt = r_count + 3'd1;
        else if (w_pop && !w_push_ok) w_count_nxt = r_count - 3'd1;
    end

    always_comb begin
        case (rwam[3:2])
            2'd0:    w_mmio_rdata = r_cycle;
            2'd2:    w_mmio_rdata = w_status;
            default: w_mmio_rdata = 32'd0;
        endcase
    end

    always_comb begin
        if (w_is_mmio)                    rdm = w_mmio_rdata;
        else if (w_mode_ok && !w_misalign) rdm = f_load(rwmm, rwam[1:0], r_mem[w_word_idx]);
        else                              rdm = 32'd0;
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_fifo[r_wr_ptr] <= wdm[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle    <= 32'd0;
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_count    <= 3'd0;
            r_ovf      <= 1'b0;
            r_misfault <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            r_count <= w_count_nxt;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 2'd1;
            // Set events take priority over a software clear in the same cycle
            if (w_push && !w_push_ok)    r_ovf <= 1'b1;
            else if (w_stat_wr && wdm[8]) r_ovf <= 1'b0;
            if (wem && w_misalign)        r_misfault <= 1'b1;
            else if (w_stat_wr && wdm[9]) r_misfault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed RAM/MMIO checks plus a queue scoreboard for TX bytes.
module tb_data_mem_responder;

    localparam logic [31:0] A_CYC  = 32'h1000_0000;
    localparam logic [31:0] A_TX   = 32'h1000_0004;
    localparam logic [31:0] A_STAT = 32'h1000_0008;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wem = 1'b0;
    logic [2:0]  rwmm = 3'd0;
    logic [31:0] rwam = 32'd0;
    logic [31:0] wdm = 32'd0;
    logic [31:0] rdm;
    logic        misalign;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;

    int n_total = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    data_mem_responder #(.DEPTH(256)) dut (
        .clk(clk), .reset_n(reset_n), .wem(wem), .rwmm(rwmm), .rwam(rwam), .wdm(wdm),
        .rdm(rdm), .misalign(misalign), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model the FIFO acceptance rule when the push is driven
    task automatic store(input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] data);
        rwmm = mode; rwam = addr; wdm = data; wem = 1'b1;
        if (addr == A_TX && (exp_q.size() < 4 || (out_ready && exp_q.size() != 0)))
            exp_q.push_back(data[7:0]);
        step();
        wem = 1'b0;
    endtask

    task automatic load(input string tag, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] exp);
        wem = 1'b0; rwmm = mode; rwam = addr;
        #1;
        chk(tag, rdm, exp);
        step();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        chk("drain_left", exp_q.size(), 0);
        chk("drain_valid", {31'd0, out_valid}, 0);
        out_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("fifo_extra", exp_q.size(), 1);
            else chk("fifo_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        end
    end

    logic [2:0]  t_mode [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] t_addr [5] = '{32'h40, 32'h40, 32'h42, 32'h42, 32'h40};
    logic [31:0] t_exp  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8000,
                                32'h0000_8000, 32'h8000_7F80};

    initial begin
        rwam = A_CYC;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_cycle", rdm, 0);
        reset_n = 1'b1;
        load("cyc0", 3'd0, A_CYC, 32'd0);
        load("cyc1", 3'd0, A_CYC, 32'd1);
        load("cyc2", 3'd0, A_CYC, 32'd2);
        load("stat_rst", 3'd0, A_STAT, 32'h2);

        store(3'b010, 32'h40, 32'h8000_7F80);
        for (int i = 0; i < 5; i++) load($sformatf("ld%0d", i), t_mode[i], t_addr[i], t_exp[i]);

        store(3'b010, 32'h44, 32'h1122_3344);
        store(3'b000, 32'h45, 32'h0000_00AB);
        load("sb_lw", 3'b010, 32'h44, 32'h1122_AB44);
        load("wrap_lw", 3'b010, 32'h444, 32'h1122_AB44);
        store(3'b011, 32'h44, 32'hFFFF_FFFF);
        load("unsup_rd", 3'b011, 32'h44, 32'h0);
        load("unsup_st", 3'b010, 32'h44, 32'h1122_AB44);

        rwmm = 3'b010; rwam = 32'h46; wdm = 32'hDEAD_BEEF; wem = 1'b1;
        #1;
        chk("mis_flag", {31'd0, misalign}, 1);
        chk("mis_rd", rdm, 0);
        step();
        wem = 1'b0;
        load("mis_ram", 3'b010, 32'h44, 32'h1122_AB44);
        load("mis_stat", 3'd0, A_STAT, 32'h202);
        store(3'd0, A_STAT, 32'h200);
        load("mis_clr", 3'd0, A_STAT, 32'h2);
        load("mis_ld", 3'b001, 32'h45, 32'h0);
        load("ld_nofault", 3'd0, A_STAT, 32'h2);
        rwmm = 3'b001; rwam = 32'h1000_0001;
        #1;
        chk("mmio_nomis", {31'd0, misalign}, 0);
        store(3'b001, 32'h46, 32'h0000_BEEF);
        load("sh_lh", 3'b001, 32'h46, 32'hFFFF_BEEF);
        load("unmapped", 3'd0, 32'h1000_000C, 32'h0);

        chk("tx_pre", {31'd0, out_valid}, 0);
        store(3'd0, A_TX, 32'h01);
        chk("tx_lat", {31'd0, out_valid}, 1);
        for (int i = 2; i <= 5; i++) store(3'd0, A_TX, i);
        load("tx_rd", 3'd0, A_TX, 32'h0);
        load("ovf_stat", 3'd0, A_STAT, 32'h111);
        store(3'd0, A_STAT, 32'h100);
        load("ovf_clr", 3'd0, A_STAT, 32'h011);
        drain();

        for (int i = 0; i < 4; i++) store(3'd0, A_TX, 32'h11 + i);
        out_ready = 1'b1;
        store(3'd0, A_TX, 32'h09);
        out_ready = 1'b0;
        load("full_pp", 3'd0, A_STAT, 32'h011);
        drain();

        store(3'b010, 32'h80, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) store(3'd0, A_TX, 32'h21 + i);
        load("pre_rst", 3'd0, A_STAT, 32'h00C);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 0);
        rwam = A_CYC;
        #1;
        chk("mid_rst_cycle", rdm, 0);
        store(3'b010, 32'h80, 32'h0);
        reset_n = 1'b1;
        load("post_rst_cyc", 3'd0, A_CYC, 32'h0);
        load("post_rst_ram", 3'b010, 32'h80, 32'hCAFE_F00D);
        load("post_rst_stat", 3'd0, A_STAT, 32'h2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
